instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Instruction fetch stage directly upstream of decode and immediate generation.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Buffers returned words with their PCs in a small FIFO and presents them to decode through a valid/ready handshake; decode drives the 32-bit instruction into the immediate generator.
- Accepts PC redirects from the branch/jump path, whose target is computed from the extended immediate, and squashes wrong-path fetches.

Parameters:
RESET_PC  32'h00000000  PC fetched first after reset
BUF_DEPTH  2  instruction buffer entries (power of two, >=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
IMemReq  output  1  request valid to instruction memory (registered)
IMemAddr  output  32  fetch address, word aligned
IMemAck  input  1  memory accepted request; IMemRData valid this cycle
IMemRData  input  32  instruction word returned
InstrValid  output  1  buffer head valid to decode
Instr  output  32  instruction word at buffer head
InstrPC  output  32  PC of Instr
DecReady  input  1  decode consumes head this cycle
Redirect  input  1  one-cycle pulse: flush, refetch from RedirectPC
RedirectPC  input  32  redirect target
FetchFault  output  1  sticky misaligned-redirect fault

Behaviour:
- Reset is asynchronous, active-high, and applies in every state. While rst is asserted: IMemReq=0, IMemAddr=RESET_PC, InstrValid=0, Instr=32'h00000013 (NOP), InstrPC=0, FetchFault=0, buffer empty, state FETCH.
- Reset mid-handshake abandons the outstanding request; memory must tolerate this.
- First cycle after reset release: IMemReq=1, IMemAddr=RESET_PC.
- Memory handshake: a request completes on any cycle where IMemReq&&IMemAck; ack in the same cycle as the first req cycle (zero-wait) is legal. IMemAddr is held stable while IMemReq=1 and no ack.
- On an accepted ack in FETCH: push {IMemAddr, IMemRData}; PC <= PC+4 (modulo 2^32, so 32'hFFFFFFFC wraps to 0).
- Next-cycle IMemReq=1 iff the state is FETCH and occupancy after this cycle's push/pop < BUF_DEPTH. This gives back-to-back fetch, one per cycle with a zero-wait memory.
- Buffer full: IMemReq drops. It re-asserts the cycle after a pop frees a slot.
- Decode handshake: pop when InstrValid&&DecReady. Instr/InstrPC come from the head entry and stay stable while InstrValid&&!DecReady. When the buffer is empty, InstrValid=0 and Instr=NOP.
- Push and pop in the same cycle leave occupancy unchanged.
- Latency: ack in cycle n with an empty buffer gives InstrValid=1 in cycle n+1.
- States:
  - FETCH: normal operation.
  - DROP: a wrong-path request is still outstanding. IMemReq stays 1 with the old address until ack, and the returned data is discarded. On ack, go to FETCH; the request to the new PC issues the next cycle.
  - HALT: IMemReq=0, nothing pushed, remain until reset.
- Redirect (highest priority; evaluated before push/pop in the same cycle):
  - Buffer flushed, so InstrValid=0 next cycle. A simultaneous pop is ignored and a simultaneous push is discarded.
  - PC <= RedirectPC.
  - If IMemReq=1 and no ack this cycle, go to DROP.
  - If ack this cycle, or no request outstanding, stay in FETCH; the request to RedirectPC issues next cycle.
  - A Redirect during DROP updates PC and stays in DROP.
- Misalignment: a Redirect with RedirectPC[1:0]!=0 sets FetchFault=1, flushes the buffer and enters HALT. An outstanding request is still completed and its data discarded before IMemReq drops. FetchFault is cleared only by reset.
- Only one request is ever outstanding. IMemAddr[1:0] is always 0.

Test Plan:
- Reset with RESET_PC=32'h00000100, zero-wait memory (ack every req cycle), DecReady=1 -> IMemAddr 0x100,0x104,0x108 on consecutive cycles; InstrValid from cycle 2 with InstrPC 0x100,0x104,0x108, data matching.
- DecReady=0 from start, zero-wait memory -> exactly 2 pushes (0x0, 0x4), IMemReq=0 afterwards, Instr stays at the 0x0 word. Raise DecReady for one cycle -> IMemReq re-asserts next cycle at 0x8.
- Memory with 3-cycle ack delay, Redirect to 0x200 one cycle after req issues for 0x10 -> req/addr 0x10 held until ack, data discarded (never InstrValid), next request 0x200, first valid InstrPC=0x200.
- Redirect same cycle as ack and as DecReady pop -> acked word dropped, buffer empty next cycle, request to the new PC next cycle.
- Start at PC 32'hFFFFFFF8 via Redirect -> fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 in order.
- Redirect to 0x00000102 -> FetchFault=1 next cycle, InstrValid=0, IMemReq stays 0; assert rst mid-fetch -> all outputs return to reset values immediately (asynchronously).

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding request to
// instruction memory and buffers returned words for decode.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   IMemReq/IMemAddr         registered request and word-aligned address
//   IMemAck/IMemRData        memory completion and returned word
//   InstrValid/Instr/InstrPC buffer head presented to decode
//   DecReady                 decode consumes the head this cycle
//   Redirect/RedirectPC      one-cycle flush and refetch from a new PC
//   FetchFault               sticky misaligned-redirect fault
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemRData,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    input  logic        DecReady,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        FetchFault
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(BUF_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH,
        S_DROP,
        S_HALT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_req;
    logic          w_req_nxt;
    logic [31:0]   r_addr;
    logic [31:0]   w_addr_nxt;
    logic [31:0]   r_pc;
    logic [31:0]   w_pc_nxt;
    logic          r_fault;
    logic          w_fault_nxt;

    logic [31:0]   r_buf_pc   [BUF_DEPTH];
    logic [31:0]   r_buf_data [BUF_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    logic          w_ack;
    logic          w_pend;
    logic          w_push;
    logic          w_pop;
    logic          w_misalign;

    assign w_ack      = r_req && IMemAck;
    // Request still waiting for memory; its address must not move.
    assign w_pend     = r_req && !IMemAck;
    assign w_misalign = Redirect && (RedirectPC[1:0] != 2'b00);
    // Redirect wins over both buffer operations in the same cycle.
    assign w_push     = w_ack && (r_state == S_FETCH) && !Redirect;
    assign w_pop      = InstrValid && DecReady && !Redirect;

    assign InstrValid = (r_cnt != '0);
    assign Instr      = InstrValid ? r_buf_data[r_rptr] : NOP;
    assign InstrPC    = InstrValid ? r_buf_pc[r_rptr] : 32'h0;
    assign IMemReq    = r_req;
    assign IMemAddr   = r_addr;
    assign FetchFault = r_fault;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (Redirect) begin
            w_cnt_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end else if (!w_push && w_pop) begin
            w_cnt_nxt = r_cnt - CW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fault_nxt = r_fault;
        unique case (r_state)
            S_FETCH, S_DROP: begin
                if (w_misalign) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = S_HALT;
                end else if (Redirect) begin
                    w_pc_nxt    = RedirectPC;
                    w_state_nxt = w_pend ? S_DROP : S_FETCH;
                end else if (r_state == S_DROP) begin
                    if (w_ack) w_state_nxt = S_FETCH;
                end else if (w_ack) begin
                    w_pc_nxt = r_pc + 32'd4;
                end
            end
            S_HALT: w_state_nxt = S_HALT;
            default: w_state_nxt = S_FETCH;
        endcase

        unique case (w_state_nxt)
            S_FETCH: w_req_nxt = (w_cnt_nxt < DEPTH);
            S_DROP:  w_req_nxt = 1'b1;
            default: w_req_nxt = w_pend;
        endcase

        w_addr_nxt = w_pend ? r_addr : w_pc_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_req   <= 1'b0;
            r_addr  <= RESET_PC;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_addr  <= w_addr_nxt;
            r_pc    <= w_pc_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (Redirect) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PW'(1);
                if (w_pop)  r_rptr <= r_rptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_wptr]   <= r_addr;
            r_buf_data[r_wptr] <= IMemRData;
        end
    end

endmodule
